// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler.
// Holds the op code values, the FSM state type and the op-legality helper.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_MUL  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_DIV  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_MOD  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_POW  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_NOT  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_LNOT = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_LAND = 4'd11;
  localparam logic [ALU_OP_W-1:0] ALU_LOR  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Codes above LOR have no ALU function behind them.
  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
    return (op <= ALU_LOR);
  endfunction

endpackage

// File: rtl/alu_sched_rr_arb.sv
// Combinational round-robin arbiter.
// req  : request vector
// ptr  : highest-priority index for this pass
// gnt  : one-hot winner (all zero when no request)
// idx  : encoded winner index
// any  : at least one request present
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    // Walk from ptr upward with wrap; first set bit wins.
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
    any = found;
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational 32-bit ALU among NREQ
// requesters. One transaction at a time: grant, hold ALU inputs ALU_LAT
// cycles, capture result with Z/N/V flags, return over valid/ready.
// Ports:
//   clk, rst            : clock, async active-high reset
//   req/req_op/req_a/b  : per-requester request, op code, operands (flat)
//   gnt                 : one-hot grant pulse, operands sampled that cycle
//   alu_ctrl/alu_a/b    : drive to the external ALU; alu_res comes back
//   rsp_*               : response channel (valid/ready) with id, data, flags
//   busy                : a transaction is in progress
module alu_sched
  import alu_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int ALU_LAT = 1,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [ALU_OP_W*NREQ-1:0] req_op,
  input  logic [32*NREQ-1:0]       req_a,
  input  logic [32*NREQ-1:0]       req_b,
  output logic [NREQ-1:0]          gnt,
  output logic [ALU_OP_W-1:0]      alu_ctrl,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  input  logic [31:0]              alu_res,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [31:0]              rsp_data,
  output logic                     rsp_z,
  output logic                     rsp_n,
  output logic                     rsp_v,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t                state, state_nxt;
  logic [IDW-1:0]        ptr;
  logic [CW-1:0]         cnt;
  logic [NREQ-1:0]       arb_gnt;
  logic [IDW-1:0]        arb_idx;
  logic                  arb_any;
  logic [ALU_OP_W-1:0]   sel_op;
  logic [31:0]           sel_a, sel_b;
  logic                  sel_illegal, sel_div0;
  logic                  ovf_add, ovf_sub;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign sel_op      = req_op[ALU_OP_W*int'(arb_idx) +: ALU_OP_W];
  assign sel_a       = req_a[32*int'(arb_idx) +: 32];
  assign sel_b       = req_b[32*int'(arb_idx) +: 32];
  assign sel_illegal = !is_legal_op(sel_op);
  assign sel_div0    = ((sel_op == ALU_DIV) || (sel_op == ALU_MOD)) && (sel_b == 32'd0);

  // Gate with rst so the combinational grant is also 0 while reset is held.
  assign gnt       = (state == ST_IDLE && !rst) ? arb_gnt : '0;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  // Overflow judged on the held operands and the live ALU result.
  assign ovf_add = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
  assign ovf_sub = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (arb_any) state_nxt = (sel_illegal || sel_div0) ? ST_RESP : ST_EXEC;
      ST_EXEC: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      cnt      <= '0;
      alu_ctrl <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_z    <= 1'b0;
      rsp_n    <= 1'b0;
      rsp_v    <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (arb_any) begin
          ptr    <= (int'(arb_idx) == NREQ-1) ? '0 : IDW'(int'(arb_idx) + 1);
          rsp_id <= arb_idx;
          if (sel_illegal) begin
            rsp_data <= '0;
            {rsp_err, rsp_z, rsp_n, rsp_v} <= 4'b1000;
          end else if (sel_div0) begin
            // Resolved locally; the ALU never sees a zero divisor.
            rsp_data <= 32'hFFFF_FFFF;
            {rsp_err, rsp_z, rsp_n, rsp_v} <= 4'b1011;
          end else begin
            alu_ctrl <= sel_op;
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            cnt      <= CW'(ALU_LAT - 1);
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data <= alu_res;
            rsp_z    <= (alu_res == 32'd0);
            rsp_n    <= alu_res[31];
            rsp_v    <= ((alu_ctrl == ALU_ADD) && ovf_add) ||
                        ((alu_ctrl == ALU_SUB) && ovf_sub);
            rsp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed scenarios plus randomized
// traffic, checked against a transaction-level reference model.
module tb_alu_sched;

  localparam int NREQ    = 4;
  localparam int ALU_LAT = 3;
  localparam int IDW     = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [4*NREQ-1:0]   req_op;
  logic [32*NREQ-1:0]  req_a, req_b;
  logic [NREQ-1:0]     gnt;
  logic [3:0]          alu_ctrl;
  logic [31:0]         alu_a, alu_b, alu_res;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_data;
  logic                rsp_z, rsp_n, rsp_v, rsp_err, busy;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  always #5 clk = ~clk;

  // Behavioural ALU sitting outside the scheduler.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 0) ? 32'd0 : a / b;
      4'd4:    return (b == 0) ? 32'd0 : a % b;
      4'd5:    return a ** b;
      4'd6:    return ~a;
      4'd7:    return a & b;
      4'd8:    return a | b;
      4'd9:    return a ^ b;
      4'd10:   return {31'd0, (a == 0)};
      4'd11:   return {31'd0, (a != 0) && (b != 0)};
      4'd12:   return {31'd0, (a != 0) || (b != 0)};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res = alu_f(alu_ctrl, alu_a, alu_b);

  alu_sched #(.NREQ(NREQ), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_v(rsp_v), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*i +: 4] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // One full transaction. Called at a negedge with inputs already driven.
  // Holds rsp_ready low for rdy_lat cycles of the response.
  task automatic txn(input int rdy_lat, output int winner);
    int w, cyc, lat, exp_lat;
    logic [3:0]      op;
    logic [31:0]     a, b, ed;
    logic            ez, en, ev, ee;
    logic [NREQ-1:0] eg;
    longint          s;
    #1;
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    winner = w;
    cyc = 0;
    while (gnt == '0 && cyc < 20) begin @(negedge clk); cyc++; end
    eg = '0;
    eg[w] = 1'b1;
    check("gnt", 32'(gnt), 32'(eg));
    op = req_op[4*w +: 4];
    a  = req_a[32*w +: 32];
    b  = req_b[32*w +: 32];
    m_ptr = (w + 1) % NREQ;
    ez = 0; en = 0; ev = 0; ee = 0;
    if (op > 4'd12) begin
      ed = 32'd0; ee = 1; exp_lat = 1;
    end else if ((op == 4'd3 || op == 4'd4) && b == 0) begin
      ed = 32'hFFFF_FFFF; ee = 1; ev = 1; en = 1; exp_lat = 1;
    end else begin
      ed = alu_f(op, a, b);
      ez = (ed == 0);
      en = ed[31];
      if (op == 4'd0) s = longint'($signed(a)) + longint'($signed(b));
      else            s = longint'($signed(a)) - longint'($signed(b));
      if (op <= 4'd1) ev = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      exp_lat = ALU_LAT + 1;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid && busy) begin
        check("exec_gnt", 32'(gnt), 32'd0);
        check("alu_ctrl", 32'(alu_ctrl), 32'(op));
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
      end
    end while (!rsp_valid && lat < 20);
    check("latency", lat, exp_lat);
    check("rsp_id", 32'(rsp_id), 32'(w));
    check("rsp_data", rsp_data, ed);
    check("rsp_flags", {rsp_err, rsp_z, rsp_n, rsp_v}, {ee, ez, en, ev});
    for (int k = 0; k < rdy_lat; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_data, ed);
      check("bp_flags", {rsp_err, rsp_z, rsp_n, rsp_v}, {ee, ez, en, ev});
      check("bp_gnt", 32'(gnt), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int w;
    int rr_exp[5];
    logic [3:0]  op;
    logic [31:0] b;
    rr_exp = '{0, 1, 2, 3, 0};
    rst = 1'b1; req = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    rst = 1'b0;

    // Round robin with every requester held high.
    req = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i), 32'(100 + i), 32'(3 + i));
    for (int n = 0; n < 5; n++) begin
      txn(0, w);
      check("rr_order", w, rr_exp[n]);
    end

    // Signed overflow on ADD.
    req = 4'b0001;
    set_req(0, 4'd0, 32'h7FFF_FFFF, 32'd1);
    txn(0, w);

    // SUB to zero.
    req = 4'b0100;
    set_req(2, 4'd1, 32'd5, 32'd5);
    txn(0, w);

    // Divide by zero never reaches the ALU.
    req = 4'b0010;
    set_req(1, 4'd3, 32'd10, 32'd0);
    txn(0, w);

    // Illegal op under 5 cycles of backpressure.
    req = 4'b1000;
    set_req(3, 4'd14, 32'd1, 32'd2);
    txn(5, w);

    // Reset while executing: pointer moves to 2 first, then is cleared.
    req = 4'b0010;
    set_req(1, 4'd0, 32'd1, 32'd2);
    #1;
    check("pre_rst_gnt", 32'(gnt), 32'b0010);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    req = '0;
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_alu", {alu_ctrl, alu_a[27:0]}, 32'd0);
    check("mid_rst_alu_b", alu_b, 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", rsp_data, 32'd0);
    m_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < ALU_LAT + 3; k++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(rsp_valid), 32'd0);
    end
    req = 4'b1110;
    for (int i = 1; i < NREQ; i++) set_req(i, 4'd7, 32'hF0F0 + 32'(i), 32'hFF00);
    txn(0, w);
    check("post_rst_winner", w, 1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      req = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        int r;
        r = $urandom_range(0, 9);
        b = $urandom;
        if (r < 7)      op = 4'($urandom_range(0, 12));
        else if (r < 8) op = 4'($urandom_range(13, 15));
        else begin op = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'd4; b = 32'd0; end
        set_req(i, op, $urandom, b);
      end
      txn($urandom_range(0, 3), w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Shares one 32-bit ALU datapath (4-bit op code, operands ain/bin, 32-bit result) between NREQ requesters.
- Uses round-robin arbitration and runs one transaction at a time.
- Drives the ALU operands/op and holds them stable for ALU_LAT cycles, then captures the result.
- Computes Z/N/V flags and returns result plus flags to the winning requester over a valid/ready response channel.
- Sits between the request ports and the ALU; the ALU itself stays combinational and unmodified.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ALU_LAT, 1, cycles the ALU inputs are held before result capture (>=1).
- IDW, $clog2(NREQ), localparam, width of requester id.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  request bit per requester; must stay high until granted.
- req_op  in  4*NREQ  op code per requester, slice i = [4i+3:4i].
- req_a  in  32*NREQ  operand A per requester.
- req_b  in  32*NREQ  operand B per requester.
- gnt  out  NREQ  one-hot, one-cycle pulse; operands sampled that cycle.
- alu_ctrl  out  4  op code to ALU.
- alu_a  out  32  operand A to ALU.
- alu_b  out  32  operand B to ALU.
- alu_res  in  32  ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  IDW  index of requester owning the response.
- rsp_data  out  32  result.
- rsp_z  out  1  result == 0.
- rsp_n  out  1  result[31].
- rsp_v  out  1  signed overflow (add/sub) or div/mod-by-zero.
- rsp_err  out  1  illegal op or div/mod by zero.
- busy  out  1  state != IDLE.

Behaviour:
- Op codes (shared package):
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 POW, 6 NOT, 7 AND, 8 OR, 9 XOR, 10 LNOT, 11 LAND, 12 LOR.
  - 13..15 are illegal.
- Reset (async, immediate): state IDLE, RR pointer 0, and all outputs 0 (gnt, alu_*, rsp_*, busy). A transaction in flight at reset is dropped; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req != 0, grant the first set bit searching from pointer upward with wrap.
  - gnt[i]=1 for that single cycle. Latch id, op, a, b. Set pointer = (i+1) mod NREQ.
  - Illegal op -> RESP with data=0, err=1, z=n=v=0.
  - DIV/MOD with b==0 -> RESP with data=32'hFFFF_FFFF, err=1, v=1, n=1, z=0; the ALU is not used.
  - Otherwise -> EXEC.
- EXEC:
  - alu_ctrl/alu_a/alu_b hold the latched values; a down-counter is loaded with ALU_LAT-1.
  - On the cycle the counter reads 0, capture alu_res into rsp_data, compute flags, -> RESP.
  - Grant to response latency = ALU_LAT+1 cycles.
- RESP:
  - rsp_valid=1; rsp_* stay stable until rsp_valid && rsp_ready, then -> IDLE.
  - rsp_valid falls the next cycle.
  - No grant is issued in a cycle where state != IDLE, so there is at least one idle cycle between a response handshake and the next gnt.
- Flags:
  - z = (data==0).
  - n = data[31].
  - ADD: v = (a[31]==b[31]) && (data[31]!=a[31]).
  - SUB: v = (a[31]!=b[31]) && (data[31]!=a[31]).
  - All other legal ops: v=0.
- alu_* outputs retain their last values in IDLE/RESP and are only meaningful in EXEC.
- Requests dropped before grant are ignored. A req that changes while not granted has no effect.
- Inputs are sampled only on the grant cycle.

Decomposition:
- Package alu_pkg:
  - op code localparams ALU_ADD..ALU_LOR and ALU_OP_W=4.
  - state encoding (IDLE/EXEC/RESP).
  - function is_legal_op.
- One sub-module rr_arb (NREQ parameter):
  - inputs req, ptr; output one-hot gnt and encoded index.
  - purely combinational.
- FSM, counter and flag logic live in alu_sched.

Test Plan:
- Single ADD: req[0], a=7FFF_FFFF, b=1 -> gnt[0] at cycle 0; rsp at cycle ALU_LAT+1 with data=8000_0000, n=1, v=1, z=0, id=0, err=0.
- SUB zero: req[2], op=1, a=b=5 -> data=0, z=1, n=0, v=0, id=2.
- Round-robin: req=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; gnt never has more than one bit set.
- Div by zero: op=3, a=10, b=0 -> rsp at cycle 1 after grant with data=FFFF_FFFF, err=1, v=1, and alu_ctrl never presents that op in EXEC.
- Backpressure and illegal op:
  - op=14 -> err=1, data=0.
  - rsp_ready held low 5 cycles -> rsp_* stable and no new gnt; release -> IDLE, next grant one cycle later.
- Reset mid-op: assert rst during EXEC with ALU_LAT=3 -> outputs 0 immediately; no rsp_valid after release; next req[1] granted first (pointer 0, req[0] low).
